// File: rtl/multi_chain_configuration_manager.sv
// rtl/multi_chain_configuration_manager.sv - parallel multi-chain fabric configuration controller
//
// Loads NUM_CHAINS configuration chains in parallel from an external bitstream
// memory. A divided programming clock is derived from clk_in. The fabric sees
// prog_reset for START_CYCLE programming-clock periods, then BITSTREAM_LENGTH
// shift cycles. The programming clock is then parked low and completion is
// flagged. A start request in DONE reruns the whole sequence.
//
// Ports:
//   clk_in             in   system clock (the only clock)
//   reset              in   synchronous, active-high
//   start              in   (re)configuration request, honoured in IDLE and DONE
//   mem_addr           out  bit index requested from the bitstream memory
//   mem_data           in   requested bit of each chain's bitstream (bit i -> chain i)
//   prog_clk           out  registered programming clock
//   prog_reset         out  programming reset to the fabric
//   ccff_head          out  configuration chain heads
//   busy               out  high while resetting or shifting the fabric
//   configuration_done out  high once configuration has completed

module multi_chain_configuration_manager #(
  parameter int NUM_CHAINS       = 4,
  parameter int BITSTREAM_LENGTH = 1024,
  parameter int CLK_DIV_SIZE     = 12,
  parameter int START_CYCLE      = 3,
  parameter bit AUTO_START       = 1'b1,
  parameter int ADDR_WIDTH       = $clog2(BITSTREAM_LENGTH)
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [NUM_CHAINS-1:0] mem_data,
  output logic                  prog_clk,
  output logic                  prog_reset,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  busy,
  output logic                  configuration_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SC_W = $clog2(START_CYCLE + 1);
  localparam int BC_W = $clog2(BITSTREAM_LENGTH + 1);

  // Divider value just before the MSB goes high (0111...1).
  localparam logic [CLK_DIV_SIZE-1:0] RISE_VAL = {1'b0, {(CLK_DIV_SIZE-1){1'b1}}};
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(BITSTREAM_LENGTH - 1);
  // Address presented after bit 0 has been taken; a one-bit stream stays at 0.
  localparam logic [ADDR_WIDTH-1:0]   NEXT_ADDR = (BITSTREAM_LENGTH > 1) ? ADDR_WIDTH'(1) : '0;
  localparam logic [SC_W-1:0]         SC_LAST   = SC_W'(START_CYCLE);
  localparam logic [BC_W-1:0]         BC_LAST   = BC_W'(BITSTREAM_LENGTH);

  logic [1:0]              state;
  logic [CLK_DIV_SIZE-1:0] div_cnt;
  logic [SC_W-1:0]         rise_cnt;
  logic [BC_W-1:0]         bit_cnt;
  logic                    rise_evt;
  logic                    fall_evt;

  // Events are decoded one clk_in cycle ahead so prog_clk can be a plain
  // flop that follows the divider MSB without any combinational output path.
  assign rise_evt = (div_cnt == RISE_VAL);
  assign fall_evt = &div_cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state              <= S_IDLE;
      div_cnt            <= '0;
      rise_cnt           <= '0;
      bit_cnt            <= '0;
      prog_clk           <= 1'b0;
      prog_reset         <= 1'b1;
      ccff_head          <= '0;
      mem_addr           <= '0;
      busy               <= 1'b0;
      configuration_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Auto-start only applies on the way out of IDLE; DONE always waits
          // for an explicit request.
          if (start || (AUTO_START && (state == S_IDLE))) begin
            state              <= S_RESET;
            div_cnt            <= '0;
            rise_cnt           <= '0;
            bit_cnt            <= '0;
            prog_clk           <= 1'b0;
            prog_reset         <= 1'b1;
            ccff_head          <= '0;
            mem_addr           <= '0;
            busy               <= 1'b1;
            configuration_done <= 1'b0;
          end
        end

        S_RESET: begin
          div_cnt <= div_cnt + CLK_DIV_SIZE'(1);
          if (rise_evt) begin
            prog_clk <= 1'b1;
            if (rise_cnt != SC_LAST) begin
              rise_cnt <= rise_cnt + SC_W'(1);
            end
          end
          if (fall_evt) begin
            prog_clk <= 1'b0;
            // Release reset and present bit 0 on a falling edge so both are
            // settled half a period before the first shifting rise.
            if (rise_cnt == SC_LAST) begin
              state      <= S_SHIFT;
              prog_reset <= 1'b0;
              ccff_head  <= mem_data;
              mem_addr   <= NEXT_ADDR;
              bit_cnt    <= '0;
            end
          end
        end

        S_SHIFT: begin
          div_cnt <= div_cnt + CLK_DIV_SIZE'(1);
          if (rise_evt) begin
            prog_clk <= 1'b1;
            bit_cnt  <= bit_cnt + BC_W'(1);
          end
          if (fall_evt) begin
            prog_clk <= 1'b0;
            if (bit_cnt == BC_LAST) begin
              // The last bit was taken by the fabric on the previous rise;
              // parking here leaves prog_clk low with no partial pulse.
              state              <= S_DONE;
              ccff_head          <= '0;
              mem_addr           <= '0;
              busy               <= 1'b0;
              configuration_done <= 1'b1;
            end else begin
              ccff_head <= mem_data;
              if (mem_addr != LAST_ADDR) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
              end
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_chain_configuration_manager.sv
// tb/tb_multi_chain_configuration_manager.sv - scoreboard bench for multi_chain_configuration_manager
module tb_multi_chain_configuration_manager;

  localparam int NC    = 2;
  localparam int LEN   = 5;
  localparam int DIVSZ = 2;
  localparam int SC    = 3;
  localparam int PER   = 1 << DIVSZ;
  localparam int RST_END = SC * PER;
  localparam int TOTAL   = (SC + LEN) * PER;

  typedef struct {
    int       dut;
    int       cycle;
    int       rises;
    logic [LEN-1:0] c0;
    logic [LEN-1:0] c1;
  } exp_t;

  logic clk = 1'b0;
  logic reset1 = 1'b1, reset2 = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  logic [2:0] addr1, addr2;
  logic [NC-1:0] mem_data1 = '0, mem_data2 = '0;
  logic prog_clk1, prog_clk2, prog_reset1, prog_reset2;
  logic [NC-1:0] head1, head2;
  logic busy1, busy2, done1, done2;

  logic [NC-1:0] mem [8];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rises_a = 0, rises_b = 0;
  logic [LEN-1:0] sr_a0 = '0, sr_a1 = '0, sr_b0 = '0, sr_b1 = '0;
  logic done_prev1 = 1'b0, done_prev2 = 1'b0;
  exp_t sb[$];

  multi_chain_configuration_manager #(
    .NUM_CHAINS(NC), .BITSTREAM_LENGTH(LEN), .CLK_DIV_SIZE(DIVSZ),
    .START_CYCLE(SC), .AUTO_START(1'b1)
  ) dut_auto (
    .clk_in(clk), .reset(reset1), .start(start1), .mem_addr(addr1),
    .mem_data(mem_data1), .prog_clk(prog_clk1), .prog_reset(prog_reset1),
    .ccff_head(head1), .busy(busy1), .configuration_done(done1)
  );

  multi_chain_configuration_manager #(
    .NUM_CHAINS(NC), .BITSTREAM_LENGTH(LEN), .CLK_DIV_SIZE(DIVSZ),
    .START_CYCLE(SC), .AUTO_START(1'b0)
  ) dut_manual (
    .clk_in(clk), .reset(reset2), .start(start2), .mem_addr(addr2),
    .mem_data(mem_data2), .prog_clk(prog_clk2), .prog_reset(prog_reset2),
    .ccff_head(head2), .busy(busy2), .configuration_done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    mem_data1 <= mem[addr1];
    mem_data2 <= mem[addr2];
  end

  // Fabric chain models: shift toward the tail on every programming-clock rise.
  always @(posedge prog_clk1) begin
    sr_a0 <= {sr_a0[LEN-2:0], head1[0]};
    sr_a1 <= {sr_a1[LEN-2:0], head1[1]};
    rises_a = rises_a + 1;
  end

  always @(posedge prog_clk2) begin
    sr_b0 <= {sr_b0[LEN-2:0], head2[0]};
    sr_b1 <= {sr_b1[LEN-2:0], head2[1]};
    rises_b = rises_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_mem(input logic [LEN-1:0] c0, input logic [LEN-1:0] c1);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < LEN; i++) mem[i] = {c1[i], c0[i]};
  endtask

  // Address 0 is shifted first, so it must end at the tail (model MSB).
  task automatic push_exp(input int d, input int t0);
    exp_t e;
    e.dut = d;
    e.cycle = t0 + TOTAL;
    e.rises = SC + LEN;
    e.c0 = '0;
    e.c1 = '0;
    for (int i = 0; i < LEN; i++) begin
      e.c0[LEN-1-i] = mem[i][0];
      e.c1[LEN-1-i] = mem[i][1];
    end
    if (d == 0) rises_a = 0; else rises_b = 0;
    sb.push_back(e);
  endtask

  task automatic check_scoreboard(input int d, input logic [LEN-1:0] c0, input logic [LEN-1:0] c1, input int nr);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_done", 32'(d), 32'hffff_ffff);
    end else begin
      e = sb.pop_front();
      check("done_dut", 32'(d), 32'(e.dut));
      check("done_cycle", 32'(cyc), 32'(e.cycle));
      check("prog_clk_rises", 32'(nr), 32'(e.rises));
      check("chain0_data", 32'(c0), 32'(e.c0));
      check("chain1_data", 32'(c1), 32'(e.c1));
    end
  endtask

  always @(negedge clk) begin
    if (done1 && !done_prev1) check_scoreboard(0, sr_a0, sr_a1, rises_a);
    if (done2 && !done_prev2) check_scoreboard(1, sr_b0, sr_b1, rises_b);
    done_prev1 = done1;
    done_prev2 = done2;
  end

  task automatic check_idle(input int d, input string tag);
    if (d == 0) begin
      check({tag, "_prog_clk"}, 32'(prog_clk1), 0);
      check({tag, "_prog_reset"}, 32'(prog_reset1), 1);
      check({tag, "_head"}, 32'(head1), 0);
      check({tag, "_addr"}, 32'(addr1), 0);
      check({tag, "_busy"}, 32'(busy1), 0);
      check({tag, "_done"}, 32'(done1), 0);
    end else begin
      check({tag, "_prog_clk"}, 32'(prog_clk2), 0);
      check({tag, "_prog_reset"}, 32'(prog_reset2), 1);
      check({tag, "_head"}, 32'(head2), 0);
      check({tag, "_addr"}, 32'(addr2), 0);
      check({tag, "_busy"}, 32'(busy2), 0);
      check({tag, "_done"}, 32'(done2), 0);
    end
  endtask

  // Cycle-by-cycle timing model relative to T (first edge in RESET).
  task automatic walk(input int d, input int t0, input int last_r, input int ign_r);
    int r;
    int k;
    logic pc, pr, b, dn;
    logic [NC-1:0] hd;
    logic [2:0] ad;
    do begin
      @(negedge clk);
      r = cyc - t0;
      if (d == 0) start1 = (r == ign_r); else start2 = (r == ign_r);
      if (d == 0) begin
        pc = prog_clk1; pr = prog_reset1; b = busy1; dn = done1; hd = head1; ad = addr1;
      end else begin
        pc = prog_clk2; pr = prog_reset2; b = busy2; dn = done2; hd = head2; ad = addr2;
      end
      check("prog_clk", 32'(pc), 32'((r < TOTAL) && ((r % PER) >= PER / 2)));
      check("prog_reset", 32'(pr), 32'(r < RST_END));
      check("busy", 32'(b), 32'(r < TOTAL));
      check("done", 32'(dn), 32'(r >= TOTAL));
      if (r < RST_END || r >= TOTAL) begin
        check("head_idle", 32'(hd), 0);
        check("addr_idle", 32'(ad), 0);
      end else begin
        k = (r - RST_END) / PER;
        check("head_shift", 32'(hd), 32'(mem[k]));
        check("addr_shift", 32'(ad), 32'((k + 1 < LEN - 1) ? k + 1 : LEN - 1));
      end
    end while (r < last_r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    set_mem(5'b01101, 5'b10110);  // chain0 stream 10110, chain1 stream 01101 (bit 0 first)
    repeat (3) @(negedge clk);
    check_idle(0, "rst_auto");
    check_idle(1, "rst_manual");

    // Power-up with a start pulse during SHIFT that must be ignored.
    reset1 = 1'b0;
    t0 = cyc + 1;
    push_exp(0, t0);
    walk(0, t0, TOTAL + 3, 20);

    // Reconfiguration from DONE with new contents.
    set_mem(5'($urandom), 5'($urandom));
    start1 = 1'b1;
    t0 = cyc + 1;
    push_exp(0, t0);
    walk(0, t0, TOTAL + 2, -1);

    // Mid-shift reset: abandon the pending result, then rerun the auto sequence.
    set_mem(5'b10011, 5'b01110);
    start1 = 1'b1;
    t0 = cyc + 1;
    push_exp(0, t0);
    walk(0, t0, 19, -1);
    reset1 = 1'b1;
    sb.delete();
    @(negedge clk);
    check_idle(0, "midreset");
    reset1 = 1'b0;
    t0 = cyc + 1;
    push_exp(0, t0);
    walk(0, t0, TOTAL + 2, -1);

    // Manual-start instance waits for start.
    set_mem(5'b11001, 5'b00111);
    reset2 = 1'b0;
    rises_b = 0;
    repeat (100) @(negedge clk);
    check("manual_no_rises", 32'(rises_b), 0);
    check("manual_busy", 32'(busy2), 0);
    check("manual_prog_reset", 32'(prog_reset2), 1);
    start2 = 1'b1;
    t0 = cyc + 1;
    push_exp(1, t0);
    walk(1, t0, TOTAL + 2, -1);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
